// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and the default
// memory read latency assumed by the MAC datapath.
package neuron_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam int RD_LAT_DEFAULT = 1;

endpackage

// File: rtl/neuron_layer_sequencer_rd_valid_pipe.sv
// Read-valid pipe: delays the read strobe by the memory read latency so the
// accumulate enable lines up with returning memory data.
module neuron_layer_sequencer_rd_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [RD_LAT-1:0] pipe_r;

    // Shift the strobe through RD_LAT stages; clear drops any reads in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            pipe_r <= '0;
        end else begin
            pipe_r[0] <= din;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    assign dout = pipe_r[RD_LAT-1];

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Layer sequencer: walks K neurons of length L through the shared MAC datapath,
// issuing x/weight reads, accumulating after the read latency, and writing results.
module neuron_layer_sequencer
    import neuron_layer_sequencer_pkg::*;
#(
    parameter int Q      = 8,
    parameter int d      = 4,
    parameter int K_W    = 4,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           st,
    input  logic [d:0]     len,
    input  logic [K_W:0]   num,
    input  logic [Q-1:0]   x_base,
    input  logic [Q-1:0]   w_base,
    input  logic           hold,
    output logic           memRead_x,
    output logic           memRead_w,
    output logic [Q-1:0]   addr_x,
    output logic [Q-1:0]   addr_w,
    output logic           clear_acc,
    output logic           acc_en,
    output logic           res_write,
    output logic [K_W-1:0] res_addr,
    output logic           busy,
    output logic           done
);

    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [DW-1:0]  DRAIN_INIT = DW'(RD_LAT - 1);
    localparam logic [DW-1:0]  DR_ONE     = DW'(1);
    localparam logic [d-1:0]   I_ONE      = d'(1);
    localparam logic [Q-1:0]   Q_ONE      = Q'(1);
    localparam logic [K_W-1:0] N_ONE      = K_W'(1);
    localparam logic [d:0]     LEN_ONE    = (d+1)'(1);
    localparam logic [K_W:0]   NUM_ONE    = (K_W+1)'(1);

    state_t         state_r;
    state_t         next_s;
    logic [d:0]     len_r;
    logic [K_W:0]   num_r;
    logic [Q-1:0]   x_base_r;
    logic [Q-1:0]   wptr_r;
    logic [d-1:0]   i_r;
    logic [K_W-1:0] n_r;
    logic [DW-1:0]  drain_r;
    logic [Q-1:0]   addr_x_r;
    logic [Q-1:0]   addr_w_r;
    logic           issue_s;
    logic           last_i_s;
    logic           last_n_s;
    logic           start_ok_s;

    assign issue_s    = (state_r == ISSUE) && !hold;
    assign last_i_s   = ({1'b0, i_r} == (len_r - LEN_ONE));
    assign last_n_s   = ({1'b0, n_r} == (num_r - NUM_ONE));
    assign start_ok_s = (len != '0) && (num != '0);

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (st) begin
                    next_s = start_ok_s ? CLEAR : FIN;
                end else begin
                    next_s = IDLE;
                end
            end
            CLEAR: next_s = ISSUE;
            ISSUE: begin
                if (issue_s && last_i_s) begin
                    next_s = DRAIN;
                end else begin
                    next_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_r == '0) begin
                    next_s = WRITE;
                end else begin
                    next_s = DRAIN;
                end
            end
            WRITE: next_s = last_n_s ? FIN : CLEAR;
            FIN:   next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Operand latches and the i / wptr / n / drain counters; wptr is never
    // rewound between neurons, which yields w_base + n*L + i without a multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r    <= '0;
            num_r    <= '0;
            x_base_r <= '0;
            wptr_r   <= '0;
            i_r      <= '0;
            n_r      <= '0;
            drain_r  <= '0;
            addr_x_r <= '0;
            addr_w_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (st) begin
                        len_r    <= len;
                        num_r    <= num;
                        x_base_r <= x_base;
                        wptr_r   <= w_base;
                        n_r      <= '0;
                    end
                end
                CLEAR: i_r <= '0;
                ISSUE: begin
                    if (issue_s) begin
                        addr_x_r <= x_base_r + Q'(i_r);
                        addr_w_r <= wptr_r;
                        i_r      <= i_r + I_ONE;
                        wptr_r   <= wptr_r + Q_ONE;
                        drain_r  <= DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    if (drain_r != '0) begin
                        drain_r <= drain_r - DR_ONE;
                    end
                end
                WRITE: begin
                    if (!last_n_s) begin
                        n_r <= n_r + N_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    neuron_layer_sequencer_rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_valid_pipe (
        .clk  (clk),
        .clr  (rst),
        .din  (issue_s),
        .dout (acc_en)
    );

    // Addresses are live while issuing and otherwise hold the last issued value.
    assign memRead_x = issue_s;
    assign memRead_w = issue_s;
    assign addr_x    = issue_s ? (x_base_r + Q'(i_r)) : addr_x_r;
    assign addr_w    = issue_s ? wptr_r : addr_w_r;
    assign clear_acc = (state_r == CLEAR);
    assign res_write = (state_r == WRITE);
    assign res_addr  = n_r;
    assign busy      = (state_r != IDLE);
    assign done      = (state_r == FIN);

endmodule
